// File: rtl/inst_loader_pkg.sv
// Shared definitions for the boot-time instruction loader.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Packs accepted bytes big-endian into 32-bit words; word_valid pulses the cycle after the 4th byte.
// Never stalls: the shift register only moves on accept, so a partial word survives source gaps.
module byte_packer
  import inst_loader_pkg::*;
(
  input  logic        Clk,
  input  logic        Clrn,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic        word_last,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0] byte_cnt;

  // High when the next accepted byte completes a word.
  assign word_last = (byte_cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      byte_cnt   <= 2'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= accept && word_last && !clear;
      if (clear) begin
        byte_cnt <= 2'd0;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        word     <= {word[23:0], byte_in};
      end
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Boot loader: length-prefixed byte frame -> imem words from address 0, CPU released on good checksum.
// Write strobe lags the 4th byte by one cycle; byte_ready depends on state only, no bubble between words.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_clrn,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  state_t          state, state_nxt;
  logic [7:0]      len_hi;
  logic [15:0]     len_n;
  logic [ADDR_W:0] words_in;
  logic [7:0]      chk_xor;
  logic            accept;
  logic            data_acc;
  logic            word_last;
  logic            word_valid;
  logic [31:0]     word;
  logic [15:0]     len_full;
  logic            last_word;

  assign byte_ready = (state == LEN_HI) || (state == LEN_LO) ||
                      (state == DATA)   || (state == CHECK);
  assign accept     = byte_valid && byte_ready;
  assign data_acc   = accept && (state == DATA);
  assign len_full   = {len_hi, byte_data};
  assign last_word  = (17'(words_in) + 17'd1) == {1'b0, len_n};

  byte_packer u_packer (
    .Clk        (Clk),
    .Clrn       (Clrn),
    .clear      (state == IDLE),
    .accept     (data_acc),
    .byte_in    (byte_data),
    .word_last  (word_last),
    .word_valid (word_valid),
    .word       (word)
  );

  assign imem_we    = word_valid;
  assign imem_wdata = word;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = LEN_HI;
      LEN_HI:  if (accept) state_nxt = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if ({1'b0, len_full} > MAX_WORDS) state_nxt = ERROR;
          else if (len_full == 16'd0)       state_nxt = CHECK;
          else                              state_nxt = DATA;
        end
      end
      DATA:    if (data_acc && word_last && last_word) state_nxt = CHECK;
      CHECK:   if (accept) state_nxt = (byte_data == chk_xor) ? DONE : ERROR;
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state        <= IDLE;
      len_hi       <= 8'd0;
      len_n        <= 16'd0;
      words_in     <= '0;
      chk_xor      <= 8'd0;
      imem_addr    <= '0;
      words_loaded <= '0;
      cpu_clrn     <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == LEN_HI && accept) len_hi <= byte_data;
      if (state == LEN_LO && accept) len_n  <= len_full;
      if (data_acc) chk_xor <= chk_xor ^ byte_data;
      if (data_acc && word_last) words_in <= words_in + (ADDR_W+1)'(1);
      // Address advances at the end of the write pulse it belongs to.
      if (word_valid) begin
        imem_addr    <= imem_addr + ADDR_W'(1);
        words_loaded <= words_loaded + (ADDR_W+1)'(1);
      end
      if (state == CHECK && state_nxt == DONE) begin
        done     <= 1'b1;
        cpu_clrn <= 1'b1;
      end
      if (state != ERROR && state_nxt == ERROR) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized scoreboard bench for inst_loader: frames built and predicted from the frame rules.
module tb_inst_loader;

  localparam int ADDR_W = 8;

  logic              Clk = 1'b0;
  logic              Clrn = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_clrn;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  inst_loader #(.ADDR_W(ADDR_W)) dut (
    .Clk          (Clk),
    .Clrn         (Clrn),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_clrn     (cpu_clrn),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  int         checks = 0;
  int         errors = 0;
  wr_t        exp_q[$];
  wr_t        mon_w;
  logic [7:0] frame_q[$];
  bit         exp_done, exp_err, load_active;
  int         exp_words, n_accept;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe pops the next expected write.
  always @(negedge Clk) begin
    if (Clrn) begin
      if (imem_we) begin
        if (exp_q.size() == 0) begin
          check("write_expected", 32'd0, 32'd1);
        end else begin
          mon_w = exp_q.pop_front();
          check("write_addr", 32'(imem_addr), 32'(mon_w.addr));
          check("write_data", imem_wdata, mon_w.data);
          check("cpu_clrn_low_at_write", 32'(cpu_clrn), 32'd0);
        end
      end
      if (load_active) check("cpu_clrn_low_during_load", 32'(cpu_clrn), 32'd0);
    end
  end

  // Reference model: decode the frame from its byte list and queue the expected writes.
  task automatic build_model();
    int n;
    logic [7:0] x;
    wr_t w;
    n = int'({frame_q[0], frame_q[1]});
    if (n > (1 << ADDR_W)) begin
      exp_err = 1'b1; exp_done = 1'b0; exp_words = 0; n_accept = 2;
    end else begin
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
        w.addr = ADDR_W'(i);
        w.data = {frame_q[2+4*i], frame_q[3+4*i], frame_q[4+4*i], frame_q[5+4*i]};
        x = x ^ frame_q[2+4*i] ^ frame_q[3+4*i] ^ frame_q[4+4*i] ^ frame_q[5+4*i];
        exp_q.push_back(w);
      end
      exp_err   = (frame_q[2+4*n] != x);
      exp_done  = !exp_err;
      exp_words = n;
      n_accept  = 2 + 4*n + 1;
    end
  endtask

  task automatic make_frame(input int n, input bit corrupt);
    logic [15:0] nn;
    logic [7:0]  b, x;
    nn = 16'(n);
    x  = 8'h00;
    frame_q.delete();
    frame_q.push_back(nn[15:8]);
    frame_q.push_back(nn[7:0]);
    for (int i = 0; i < 4*n; i++) begin
      b = 8'($urandom);
      x = x ^ b;
      frame_q.push_back(b);
    end
    frame_q.push_back(corrupt ? (x ^ 8'($urandom_range(1, 255))) : x);
  endtask

  // Offer one byte from a negedge; returns at the negedge after acceptance.
  task automatic put_byte(input logic [7:0] b, input int budget, output bit ok);
    int t;
    ok = 1'b0;
    t  = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!ok && t < budget) begin
      if (byte_ready) begin
        @(posedge Clk);
        @(negedge Clk);
        ok = 1'b1;
      end else begin
        @(negedge Clk);
        t++;
      end
    end
  endtask

  task automatic send_bytes(input int cnt, input int gap_max, input bit release_last);
    bit ok;
    bit aborted;
    aborted = 1'b0;
    for (int i = 0; i < cnt && !aborted; i++) begin
      if (gap_max > 0) begin
        byte_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge Clk);
      end
      if (release_last && i == cnt - 1) load_active = 1'b0;
      put_byte(frame_q[i], 200, ok);
      if (!ok) begin
        check("byte_accepted", 32'd0, 32'd1);
        aborted = 1'b1;
      end
    end
  endtask

  task automatic run_frame(input string tag, input int gap_max);
    bit ok;
    build_model();
    send_bytes(n_accept, gap_max, 1'b1);
    put_byte(8'h5A, 10, ok);
    check({tag, "_extra_byte_refused"}, 32'(ok), 32'd0);
    byte_valid  = 1'b0;
    load_active = 1'b0;
    repeat (3) @(negedge Clk);
    check({tag, "_done"},         32'(done),         32'(exp_done));
    check({tag, "_error"},        32'(error),        32'(exp_err));
    check({tag, "_cpu_clrn"},     32'(cpu_clrn),     32'(exp_done));
    check({tag, "_byte_ready"},   32'(byte_ready),   32'd0);
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'(exp_words));
    check({tag, "_writes_left"},  32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_byte_ready"},   32'(byte_ready),   32'd0);
    check({tag, "_imem_we"},      32'(imem_we),      32'd0);
    check({tag, "_imem_addr"},    32'(imem_addr),    32'd0);
    check({tag, "_imem_wdata"},   imem_wdata,        32'd0);
    check({tag, "_cpu_clrn"},     32'(cpu_clrn),     32'd0);
    check({tag, "_done"},         32'(done),         32'd0);
    check({tag, "_error"},        32'(error),        32'd0);
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic do_reset();
    Clrn       = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'($urandom);
    exp_q.delete();
    repeat (2) @(negedge Clk);
    check_reset_vals("reset");
    Clrn = 1'b1;
    #1;
    check("ready_first_cycle", 32'(byte_ready), 32'd0);
    @(negedge Clk);
    check("ready_second_cycle", 32'(byte_ready), 32'd1);
    byte_valid  = 1'b0;
    load_active = 1'b1;
  endtask

  initial begin
    wr_t w;

    do_reset();
    frame_q = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h02, 8'h00, 8'h00, 8'h8A};
    run_frame("good2", 0);

    do_reset();
    frame_q = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h02, 8'h00, 8'h00, 8'h8B};
    run_frame("badchk", 0);

    do_reset();
    frame_q = '{8'h00, 8'h00, 8'h00};
    run_frame("empty", 0);

    do_reset();
    frame_q = '{8'h01, 8'h01, 8'h11, 8'h22, 8'h33};
    run_frame("toolong", 0);

    do_reset();
    make_frame(1 << ADDR_W, 1'b0);
    run_frame("full", 0);

    for (int k = 0; k < 6; k++) begin
      do_reset();
      make_frame($urandom_range(1, 8), ($urandom_range(0, 2) == 0));
      run_frame("random", 3);
    end

    // Reset after two bytes of word 1: only word 0 may be written.
    do_reset();
    make_frame(3, 1'b0);
    w.addr = '0;
    w.data = {frame_q[2], frame_q[3], frame_q[4], frame_q[5]};
    exp_q.push_back(w);
    send_bytes(8, 3, 1'b0);
    byte_valid = 1'b0;
    repeat (2) @(negedge Clk);
    #2;
    Clrn = 1'b0;
    #1;
    check_reset_vals("midreset");
    check("midreset_writes_left", 32'(exp_q.size()), 32'd0);
    load_active = 1'b0;

    do_reset();
    make_frame(4, 1'b0);
    run_frame("after_reset", 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
- Boot-time instruction loader upstream of the instruction-fetch stage.
- Receives a framed byte stream over a valid/ready handshake and packs it into 32-bit instruction words.
- Writes the words into instruction memory from word address 0 upward.
- Holds the CPU in reset until the whole image has arrived and its checksum matches.

Parameters:
ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words

Ports:
Clk  in  1  system clock, rising edge
Clrn  in  1  asynchronous active-low reset
byte_valid  in  1  source presents byte_data
byte_data  in  8  stream byte
byte_ready  out  1  loader accepts a byte this cycle
imem_we  out  1  instruction-memory write strobe, one-cycle pulse
imem_addr  out  ADDR_W  word address for the write
imem_wdata  out  32  instruction word for the write
cpu_clrn  out  1  active-low reset for the CPU; high only after a successful load
done  out  1  load completed, checksum good
error  out  1  load failed, sticky
words_loaded  out  ADDR_W+1  count of words written so far

Behaviour:
- Clock and reset: one clock, Clk. Reset is Clrn, asynchronous and active-low.
- While Clrn is low, all registers clear:
  - state = IDLE
  - byte_ready = 0, imem_we = 0, imem_addr = 0, imem_wdata = 0
  - cpu_clrn = 0, done = 0, error = 0, words_loaded = 0
- Transfer rule: a byte is accepted at a rising edge where byte_valid & byte_ready.
- byte_ready is decoded from state only. It is 1 in LEN_HI, LEN_LO, DATA and CHECK, and 0 otherwise. It does not depend on byte_valid.
- Frame format:
  - LEN: 2 bytes, big-endian word count N.
  - DATA: N×4 bytes, each word big-endian (first byte goes to bits 31:24).
  - CHK: 1 byte, equal to the XOR of all DATA bytes.
- FSM transitions:
  - IDLE -> LEN_HI: unconditionally, one cycle after reset release.
  - LEN_HI -> LEN_LO: on accept; the byte is latched as N[15:8].
  - LEN_LO: on accept, N[7:0] is latched, then:
    - N > 2^ADDR_W -> ERROR
    - N == 0 -> CHECK
    - otherwise -> DATA
  - DATA:
    - A 2-bit byte counter and a shift register assemble each word.
    - The running XOR is updated on every accepted DATA byte.
    - On the 4th byte, the next cycle drives imem_we = 1 with the assembled word and the current word address. The address and words_loaded increment at the end of that pulse.
    - Acceptance continues during the write pulse, with no bubble.
    - After the 4th byte of word N-1 -> CHECK.
  - CHECK: on accept, byte == running XOR -> DONE, else -> ERROR.
  - DONE: terminal. done = 1, cpu_clrn = 1, both registered and set on entry.
  - ERROR: terminal. error = 1, cpu_clrn stays 0.
  - DONE and ERROR are left only via Clrn.
- Ordering guarantee: the final imem_we pulse always occurs no later than the cycle cpu_clrn first rises.
- Arithmetic:
  - The word address is a plain ADDR_W-bit counter. It never wraps, because N > 2^ADDR_W is rejected.
  - words_loaded is ADDR_W+1 bits wide so that it can hold exactly 2^ADDR_W.
  - The XOR starts at 0x00, so an N == 0 frame needs CHK = 0x00.
- Bytes offered in IDLE, DONE or ERROR are not accepted (byte_ready = 0); the source must hold them.
- Reset mid-frame: the partial word is discarded, no write is issued, cpu_clrn drops immediately (asynchronously), and memory words already written are left as is.
- byte_valid deasserted mid-word: the loader waits indefinitely with no timeout, and the partial word is retained.

Decomposition:
- Shared package contains:
  - FSM state encodings: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR.
  - Constant BYTES_PER_WORD = 4.
- One sub-module, byte_packer:
  - Holds the 2-bit byte counter and the 32-bit shift register.
  - Takes accept and byte inputs and a clear input.
  - Outputs word_valid, a registered one-cycle pulse, and word[31:0].
  - inst_loader derives imem_we directly from word_valid.

Test Plan:
- Reset, then hold byte_valid = 1:
  - byte_ready must be 0 in the first cycle after release and 1 from the second.
  - cpu_clrn = 0 throughout the load.
- Frame 00 02 | 20 01 00 05 | AC 02 00 00 | CHK = 0x20^0x01^0x05^0xAC^0x02 = 0x8A, streamed back-to-back:
  - imem_we pulses at addr 0 with 0x20010005, then at addr 1 with 0xAC020000.
  - words_loaded = 2, then done = 1, cpu_clrn = 1, byte_ready = 0.
- Same frame with CHK = 0x8B:
  - error = 1, cpu_clrn stays 0, both words are still written, further bytes are not accepted.
- Frame 00 00 00:
  - no imem_we, done = 1, cpu_clrn = 1.
- With ADDR_W = 8, length 01 01 (257):
  - error = 1 right after LEN_LO, no writes.
  - Length 01 00 with 1024 bytes and correct CHK: last write at addr 0xFF, words_loaded = 256, done = 1.
- Random byte_valid gaps mid-word, then pull Clrn low after 2 bytes of word 1:
  - no write for word 1, all outputs at reset values.
  - A subsequent clean frame loads correctly from addr 0.
